// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parameterised serial-pattern detector.
// Imported by the top module and by the saturating match counter.
package seq_detect_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [5:0] DEFAULT_PATTERN = 6'b111010;

  // Largest value a counter of width w can hold before it must stop.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Stream, pattern-load and result signals of the serial-pattern detector.
// master = the side driving the bit stream, slave = the detector.
interface seq_detect_if #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_seq;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             det_out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in_valid, in_seq, overlap_en, pat_load, pat_in,
    input  det_out, match_cnt
  );

  modport slave (
    input  in_valid, in_seq, overlap_en, pat_load, pat_in,
    output det_out, match_cnt
  );

endinterface

// File: rtl/seq_detect_sat_cnt.sv
// Saturating up-counter with increment enable and async active-high reset.
// Holds at its maximum value instead of wrapping.
module seq_detect_sat_cnt
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc_en && (count != MAX_CNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised Mealy serial-pattern detector, runtime-loadable pattern, overlap select.
// Define SEQ_DETECT_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = 6,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W       = 8
) (
  input logic         clk,
  input logic         rst,
  seq_detect_if.slave bus
);

  localparam int               FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W - 1);

  state_e             state, state_nxt;
  logic [PAT_W-1:0]   pattern, pattern_nxt;
  logic [PAT_W-2:0]   hist, hist_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic               det;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      pattern <= DEF_PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
    end
  end

  // A load discards the current bit and restarts filling; a non-overlapping match
  // also restarts so the matched bits cannot contribute to the next match.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    hist_nxt    = hist;
    fill_nxt    = fill;
    det         = 1'b0;
    if (bus.pat_load) begin
      pattern_nxt = bus.pat_in;
      hist_nxt    = '0;
      fill_nxt    = '0;
      state_nxt   = FILL;
    end else if (bus.in_valid) begin
      det = (state == ARMED) && ({hist, bus.in_seq} == pattern);
      if (det && !bus.overlap_en) begin
        hist_nxt  = '0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        hist_nxt = (PAT_W-1)'({hist, bus.in_seq});
        if (fill != FULL) begin
          fill_nxt = fill + 1'b1;
        end
        state_nxt = (fill_nxt == FULL) ? ARMED : FILL;
      end
    end
  end

  assign bus.det_out = det;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  seq_detect_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (det),
    .count  (cnt)
  );
`else
  assign cnt = '0;
`endif

  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (6/8, 4/8, 6/2 bits) share one stream and
// are compared each cycle against a queue-based reference model, plus directed scenarios.
module tb_seq_detect_param;

  localparam int NDUT = 3;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_detect_if #(.PAT_W(6), .CNT_W(8)) bus0 ();
  seq_detect_if #(.PAT_W(4), .CNT_W(8)) bus1 ();
  seq_detect_if #(.PAT_W(6), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_W(6), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seq_detect_param #(.PAT_W(6), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int          pat_w [NDUT] = '{6, 4, 6};
  int          cnt_w [NDUT] = '{8, 8, 2};
  logic [31:0] m_pat [NDUT];
  bit          m_q   [NDUT][$];
  int unsigned m_cnt [NDUT];
  int          hits  [NDUT];

  int num_checks = 0;
  int num_fail   = 0;

  function automatic logic [31:0] mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] expCnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  function automatic logic detObs(input int d);
    case (d)
      0:       return bus0.det_out;
      1:       return bus1.det_out;
      default: return bus2.det_out;
    endcase
  endfunction

  function automatic logic [31:0] cntObs(input int d);
    case (d)
      0:       return 32'(bus0.match_cnt);
      1:       return 32'(bus1.match_cnt);
      default: return 32'(bus2.match_cnt);
    endcase
  endfunction

  // Reference: the last PAT_W-1 accepted bits since the last restart, then the live bit.
  function automatic bit modelDet(input int d, input bit valid, input bit load, input bit seq);
    logic [31:0] val;
    int n;
    int sz;
    if (!valid || load) return 1'b0;
    n  = pat_w[d] - 1;
    sz = m_q[d].size();
    if (sz < n) return 1'b0;
    val = '0;
    for (int i = sz - n; i < sz; i++) val = (val << 1) | 32'(m_q[d][i]);
    val = (val << 1) | 32'(seq);
    return val == m_pat[d];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < NDUT; d++) begin
      m_pat[d] = 32'b111010 & mask(pat_w[d]);
      m_q[d].delete();
      m_cnt[d] = 0;
      hits[d]  = 0;
    end
  endtask

  task automatic driveAll(input bit valid, input bit seq, input bit ovl, input bit load,
                          input logic [31:0] patv);
    bus0.in_valid = valid; bus0.in_seq = seq; bus0.overlap_en = ovl;
    bus0.pat_load = load;  bus0.pat_in = patv[5:0];
    bus1.in_valid = valid; bus1.in_seq = seq; bus1.overlap_en = ovl;
    bus1.pat_load = load;  bus1.pat_in = patv[3:0];
    bus2.in_valid = valid; bus2.in_seq = seq; bus2.overlap_en = ovl;
    bus2.pat_load = load;  bus2.pat_in = patv[5:0];
  endtask

  // One clock cycle: drive, check the Mealy output and counter, advance the model.
  task automatic applyStimulus(input bit valid, input bit seq, input bit ovl, input bit load,
                               input logic [31:0] patv);
    bit exp_det [NDUT];
    @(negedge clk);
    driveAll(valid, seq, ovl, load, patv);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      exp_det[d] = modelDet(d, valid, load, seq);
      checkOutput($sformatf("det%0d", d), 32'(detObs(d)), 32'(exp_det[d]));
      checkOutput($sformatf("cnt%0d", d), cntObs(d), CNT_EN ? 32'(m_cnt[d]) : 32'd0);
      if (detObs(d) === 1'b1) hits[d]++;
    end
    for (int d = 0; d < NDUT; d++) begin
      if (load) begin
        m_pat[d] = patv & mask(pat_w[d]);
        m_q[d].delete();
      end else if (valid) begin
        if (exp_det[d]) begin
          if (CNT_EN && (32'(m_cnt[d]) < mask(cnt_w[d]))) m_cnt[d]++;
          if (ovl) m_q[d].push_back(seq);
          else     m_q[d].delete();
        end else begin
          m_q[d].push_back(seq);
        end
        if (m_q[d].size() > 32) void'(m_q[d].pop_front());
      end
    end
  endtask

  task automatic sendBits(input logic [31:0] bits, input int n, input bit ovl);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], ovl, 1'b0, 32'd0);
  endtask

  task automatic doReset();
    driveAll(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("rst_det%0d", d), 32'(detObs(d)), 32'd0);
      checkOutput($sformatf("rst_cnt%0d", d), cntObs(d), 32'd0);
    end
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bit ovl;
    bit run_mode;
    bit run_bit;
    logic [31:0] patv;

    rst = 1'b0;
    modelReset();

    // Default pattern, non-overlapping, two back-to-back frames.
    doReset();
    sendBits(32'b111010_111010, 12, 1'b0);
    checkOutput("t1_hits", 32'(hits[0]), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("t1_cnt", cntObs(0), expCnt(2));

    // Loaded 1010 on the 4-bit instance, overlapping then non-overlapping.
    for (int m = 1; m >= 0; m--) begin
      doReset();
      applyStimulus(1'b0, 1'b0, 1'(m), 1'b1, 32'b1010);
      sendBits(32'b1010_1010, 8, 1'(m));
      checkOutput($sformatf("t2_hits_ovl%0d", m), 32'(hits[1]), (m == 1) ? 32'd3 : 32'd2);
      applyStimulus(1'b0, 1'b0, 1'(m), 1'b0, 32'd0);
      checkOutput($sformatf("t2_cnt_ovl%0d", m), cntObs(1), expCnt((m == 1) ? 3 : 2));
    end

    // Valid gaps do not disturb the history.
    doReset();
    sendBits(32'b111, 3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 32'd0);
    sendBits(32'b010, 3, 1'b0);
    checkOutput("t3_hits", 32'(hits[0]), 32'd1);

    // Load mid-pattern discards the partial match and its bit.
    doReset();
    sendBits(32'b11101, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'b111010);
    sendBits(32'b111010, 6, 1'b0);
    checkOutput("t4_hits", 32'(hits[0]), 32'd1);

    // Async reset between edges while a match is being presented.
    doReset();
    sendBits(32'b111010, 6, 1'b0);
    sendBits(32'b11101, 5, 1'b0);
    @(negedge clk);
    driveAll(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t5_det_pre", 32'(bus0.det_out), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("t5_det_rst%0d", d), 32'(detObs(d)), 32'd0);
      checkOutput($sformatf("t5_cnt_rst%0d", d), cntObs(d), 32'd0);
    end
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    sendBits(32'b0, 1, 1'b0);
    sendBits(32'b111010, 6, 1'b0);
    checkOutput("t5_hits", 32'(hits[0]), 32'd1);

    // Constant ones against an all-ones pattern saturates the 2-bit counter.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'b111111);
    sendBits(32'hFFF, 12, 1'b1);
    checkOutput("t6_hits", 32'(hits[2]), 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("t6_cnt_sat", cntObs(2), expCnt(3));
    checkOutput("t6_cnt_wide", cntObs(0), expCnt(7));

    // Randomised traffic against the reference model.
    doReset();
    ovl      = 1'b1;
    run_mode = 1'b0;
    run_bit  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) ovl = ~ovl;
      if ($urandom_range(0, 31) == 0) begin
        run_mode = ~run_mode;
        run_bit  = 1'($urandom);
      end
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       patv = 32'd0;
          1:       patv = 32'hFFFF_FFFF;
          default: patv = $urandom;
        endcase
        applyStimulus(1'($urandom), 1'($urandom), ovl, 1'b1, patv);
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, run_mode ? run_bit : 1'($urandom),
                      ovl, 1'b0, 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
